// File: rtl/rx_frame_sequencer.sv
// Receive frame sequencer: walks SFD -> DA -> L/T -> DATA -> CRC verdict, counts bytes and collects errors.
// Status (frame_len, err_vec, good/bad pulse) is registered one cycle after the terminating cycle; no backpressure.
module rx_frame_sequencer #(
  parameter int BYTES     = 8,
  parameter int LEN_W     = 14,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int JUMBO_LEN = 9018,
  parameter int CRC_TO    = 16
) (
  input  logic                   rxclk,
  input  logic                   reset,
  input  logic                   recv_enable,
  input  logic                   get_sfd,
  input  logic                   beat_valid,
  input  logic                   last_beat,
  input  logic [$clog2(BYTES):0] beat_bytes,
  input  logic                   local_invalid,
  input  logic                   get_error_code,
  input  logic                   tagged_frame,
  input  logic [15:0]            lt_field,
  input  logic                   jumbo_enable,
  input  logic                   crc_check_valid,
  input  logic                   crc_check_invalid,
  output logic                   start_da,
  output logic                   start_lt,
  output logic                   start_data_cnt,
  output logic                   start_tagged_cnt,
  output logic                   receiving_frame,
  output logic                   recv_end,
  output logic                   wait_crc_check,
  output logic                   good_frame_get,
  output logic                   bad_frame_get,
  output logic                   status_valid,
  output logic [LEN_W-1:0]       frame_len,
  output logic [6:0]             err_vec,
  output logic                   sfd_overrun
);

  localparam int TO_W = $clog2(CRC_TO + 1);

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    DA       = 6'b000010,
    LT       = 6'b000100,
    DATA     = 6'b001000,
    CRC_WAIT = 6'b010000,
    DROP     = 6'b100000
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, cnt_add, len_now;
  logic [LEN_W:0]    inc, sum;
  logic [6:0]        err_acc, err_nxt, end_err, last_err;
  logic [TO_W-1:0]   crc_tmr;
  logic              in_rx, end_fire, clr;
  logic              too_long, runt, len_err;
  logic [31:0]       len32, tag_add, max_len, exp_a, exp_b, exp_len;

  // Byte counter: full beats add BYTES, the closing beat adds its valid bytes; saturates.
  assign inc     = last_beat ? (LEN_W+1)'(beat_bytes) : (LEN_W+1)'(BYTES);
  assign sum     = {1'b0, cnt} + inc;
  assign cnt_add = sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
  assign in_rx   = (state == DA) || (state == LT) || (state == DATA);
  assign len_now = (in_rx && beat_valid) ? cnt_add : cnt;

  assign len32    = 32'(len_now);
  assign tag_add  = tagged_frame ? 32'd4 : 32'd0;
  assign max_len  = jumbo_enable ? 32'(JUMBO_LEN) : 32'(MAX_LEN) + tag_add;
  assign exp_a    = 32'(lt_field) + 32'd18 + tag_add;
  assign exp_b    = 32'(MIN_LEN) + tag_add;
  assign exp_len  = (exp_a > exp_b) ? exp_a : exp_b;
  assign too_long = len32 > max_len;
  assign runt     = len32 < 32'(MIN_LEN);
  assign len_err  = (lt_field <= 16'd1500) && (len32 != exp_len);
  assign last_err = {2'b00, len_err, runt, 3'b000};

  assign start_da         = (state == DA);
  assign start_lt         = (state == LT);
  assign start_data_cnt   = (state == DATA) && !tagged_frame;
  assign start_tagged_cnt = (state == DATA) && tagged_frame;
  assign receiving_frame  = in_rx;
  assign recv_end         = !in_rx;
  assign wait_crc_check   = (state == CRC_WAIT);

  always_comb begin
    state_nxt = state;
    err_nxt   = err_acc;
    end_err   = err_acc;
    end_fire  = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (get_sfd && recv_enable) begin
          state_nxt = DA;
          clr       = 1'b1;
          err_nxt   = '0;
        end
      end
      DA, LT: begin
        if (beat_valid) begin
          if (last_beat) begin
            state_nxt = CRC_WAIT;
            err_nxt   = err_acc | last_err;
          end else begin
            state_nxt = (state == DA) ? LT : DATA;
          end
        end
      end
      DATA: begin
        if (get_error_code) begin
          end_err   = err_acc | 7'b0000001;
          err_nxt   = end_err;
          end_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (local_invalid || (beat_valid && too_long)) begin
          end_err = err_acc | {4'b0000, beat_valid && too_long && !local_invalid, local_invalid, 1'b0};
          err_nxt = end_err;
          // An abort on the closing beat has nothing left to drop, so it ends here.
          if (beat_valid && last_beat) begin
            end_fire  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DROP;
          end
        end else if (beat_valid && last_beat) begin
          state_nxt = CRC_WAIT;
          err_nxt   = err_acc | last_err;
        end
      end
      CRC_WAIT: begin
        if (crc_check_invalid) begin
          end_err   = err_acc | 7'b0100000;
          end_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (crc_check_valid) begin
          end_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (crc_tmr == TO_W'(CRC_TO - 1)) begin
          end_err   = err_acc | 7'b1000000;
          end_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (beat_valid && last_beat) begin
          end_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      err_acc        <= '0;
      crc_tmr        <= '0;
      status_valid   <= 1'b0;
      good_frame_get <= 1'b0;
      bad_frame_get  <= 1'b0;
      frame_len      <= '0;
      err_vec        <= '0;
      sfd_overrun    <= 1'b0;
    end else begin
      state          <= state_nxt;
      err_acc        <= err_nxt;
      cnt            <= clr ? '0 : len_now;
      crc_tmr        <= (state == CRC_WAIT) ? crc_tmr + TO_W'(1) : '0;
      status_valid   <= end_fire;
      good_frame_get <= end_fire && (end_err == 7'd0);
      bad_frame_get  <= end_fire && (end_err != 7'd0);
      sfd_overrun    <= get_sfd && ((state == CRC_WAIT) || (state == DROP));
      if (end_fire) begin
        frame_len <= len_now;
        err_vec   <= end_err;
      end
    end
  end

endmodule
